// File: rtl/fifo_pop_arbiter.sv
// fifo_pop_arbiter: pops one word at a time from NUM_CH source FIFOs onto a shared output (define FIFO_ARB_FIXED_PRIO_EN for fixed priority)
module fifo_pop_arbiter #(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 16,
   parameter int CH_BITS    = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_enable,
   input  logic [NUM_CH-1:0]            i_mask,
   input  logic [NUM_CH-1:0]            i_fifo_empty,
   input  logic [NUM_CH*DATA_WIDTH-1:0] i_fifo_data,
   output logic [NUM_CH-1:0]            o_fifo_pop,
   output logic [DATA_WIDTH-1:0]        o_data,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic [CH_BITS-1:0]           o_grant_id,
   output logic                         o_busy
);
   typedef enum logic [1:0] {IDLE, POP, CAPT, HOLD} state_t;
   state_t              state;
   logic [NUM_CH-1:0]   req;
   logic [CH_BITS-1:0]  winner;
   logic                found;
   assign req = ~i_fifo_empty & ~i_mask;
`ifdef FIFO_ARB_FIXED_PRIO_EN
   // lowest-index requesting channel wins
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (req[i]) begin
            winner = CH_BITS'(i);
            found  = 1'b1;
         end
   end
`else
   logic [CH_BITS-1:0]  rr_ptr;
   int                  idx;
   // first requesting channel after the last grant, wrapping at NUM_CH
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = (int'(rr_ptr) + i) % NUM_CH;
         if (!found && req[idx[CH_BITS-1:0]]) begin
            winner = idx[CH_BITS-1:0];
            found  = 1'b1;
         end
      end
   end
   // remember the last grant; reset value makes channel 0 win first
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rr_ptr <= CH_BITS'(NUM_CH - 1);
      else if (state == IDLE && i_enable && found) rr_ptr <= winner;
`endif
   // transaction FSM: grant, pop for one cycle, capture read data, hold until accepted
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         o_fifo_pop <= '0;
         o_valid    <= 1'b0;
         o_data     <= '0;
         o_grant_id <= '0;
         o_busy     <= 1'b0;
      end else
         case (state)
            IDLE: if (i_enable && found) begin
               state      <= POP;
               o_grant_id <= winner;
               o_fifo_pop <= NUM_CH'(1) << winner;
               o_busy     <= 1'b1;
            end
            POP: begin
               state      <= CAPT;
               o_fifo_pop <= '0;
            end
            CAPT: begin
               state   <= HOLD;
               o_data  <= i_fifo_data[o_grant_id*DATA_WIDTH +: DATA_WIDTH];
               o_valid <= 1'b1;
            end
            HOLD: if (i_ready) begin
               state   <= IDLE;
               o_valid <= 1'b0;
               o_busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// tb_fifo_pop_arbiter: directed and random checks of fifo_pop_arbiter against a transaction-level model
module tb_fifo_pop_arbiter;
   localparam int N = 4;
   localparam int W = 16;
   logic           clk = 1'b0, rst_n = 1'b0, i_enable = 1'b0, i_ready = 1'b0;
   logic [N-1:0]   i_mask = '0, i_fifo_empty = '1;
   logic [N*W-1:0] i_fifo_data = '0;
   logic [N-1:0]   o_fifo_pop;
   logic [W-1:0]   o_data;
   logic           o_valid, o_busy;
   logic [1:0]     o_grant_id;
   logic [W-1:0]   q[N][$];
   logic [W-1:0]   rd[N];
   int             total = 0, bad = 0;
   int             age = 0, m_rr = N - 1, m_gid = 0;
   logic [W-1:0]   m_data = '0, m_word = '0;
   int             dut_g[$];

   always #5 clk = ~clk;

   fifo_pop_arbiter #(.NUM_CH(N), .DATA_WIDTH(W), .CH_BITS(2)) dut (
      .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_mask(i_mask),
      .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data), .o_fifo_pop(o_fifo_pop),
      .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_grant_id(o_grant_id),
      .o_busy(o_busy)
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(logic [N-1:0] r);
`ifdef FIFO_ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (r[i]) return i;
`else
      for (int i = 1; i <= N; i++) if (r[(m_rr + i) % N]) return (m_rr + i) % N;
`endif
      return 0;
   endfunction

   task automatic drive_fifo();
      for (int n = 0; n < N; n++) begin
         i_fifo_empty[n] = (q[n].size() == 0);
         i_fifo_data[n*W +: W] = rd[n];
      end
   endtask

   task automatic model_reset();
      age = 0; m_rr = N - 1; m_gid = 0; m_data = '0;
   endtask

   task automatic check_outputs(string tag);
      chk({tag, "_pop"}, 32'(o_fifo_pop), age == 1 ? 32'(1 << m_gid) : 32'd0);
      chk({tag, "_valid"}, 32'(o_valid), 32'(age >= 3));
      chk({tag, "_busy"}, 32'(o_busy), 32'(age != 0));
      chk({tag, "_gid"}, 32'(o_grant_id), 32'(m_gid));
      chk({tag, "_data"}, 32'(o_data), 32'(m_data));
   endtask

   task automatic tick();
      logic [N-1:0] popped;
      logic [N-1:0] r;
      popped = o_fifo_pop;
      drive_fifo();
      r = ~i_fifo_empty & ~i_mask;
      if (rst_n) begin
         if (age == 0) begin
            if (i_enable && r != 0) begin
               m_gid = pick(r);
               m_rr = m_gid;
               m_word = q[m_gid][0];
               age = 1;
            end
         end else if (age >= 3) begin
            if (i_ready) age = 0;
         end else begin
            age++;
            if (age == 3) m_data = m_word;
         end
      end
      @(posedge clk);
      #1;
      for (int n = 0; n < N; n++)
         if (popped[n] && q[n].size() > 0) rd[n] = q[n].pop_front();
      drive_fifo();
      if (o_fifo_pop != 0) dut_g.push_back($clog2(o_fifo_pop));
      check_outputs("cyc");
   endtask

   task automatic fill(int depth);
      for (int n = 0; n < N; n++)
         while (q[n].size() < depth) q[n].push_back(W'($urandom));
   endtask

   task automatic sync_reset();
      rst_n = 1'b0;
      model_reset();
      tick();
      tick();
      rst_n = 1'b1;
      dut_g.delete();
   endtask

   initial begin
      int exp_rr[5];
      int exp_mk[4];
      for (int n = 0; n < N; n++) rd[n] = '0;
      #1;
      check_outputs("rst");
      tick();
      tick();
      rst_n = 1'b1;
      // single word on channel 0, held with i_ready low
      q[0].push_back(16'hA5A5);
      i_enable = 1'b1;
      tick();
      chk("first_pop", 32'(o_fifo_pop), 32'd1);
      tick();
      tick();
      chk("first_valid", 32'(o_valid), 32'd1);
      chk("first_data", 32'(o_data), 32'hA5A5);
      chk("first_gid", 32'(o_grant_id), 32'd0);
      for (int k = 0; k < 10; k++) tick();
      chk("hold_data", 32'(o_data), 32'hA5A5);
      i_ready = 1'b1;
      tick();
      chk("accept_valid", 32'(o_valid), 32'd0);
      // all channels non-empty, continuous ready
      sync_reset();
      fill(6);
`ifdef FIFO_ARB_FIXED_PRIO_EN
      exp_rr = '{0, 0, 0, 0, 0};
      exp_mk = '{1, 1, 1, 1};
`else
      exp_rr = '{0, 1, 2, 3, 0};
      exp_mk = '{1, 3, 1, 3};
`endif
      for (int k = 0; k < 20; k++) tick();
      chk("rr_count", 32'(dut_g.size()), 32'd5);
      for (int k = 0; k < 5 && k < dut_g.size(); k++) chk("rr_order", 32'(dut_g[k]), 32'(exp_rr[k]));
      // masked channels 0 and 2
      sync_reset();
      fill(6);
      i_mask = 4'b0101;
      for (int k = 0; k < 16; k++) tick();
      chk("mask_count", 32'(dut_g.size()), 32'd4);
      for (int k = 0; k < 4 && k < dut_g.size(); k++) chk("mask_order", 32'(dut_g[k]), 32'(exp_mk[k]));
      i_mask = '0;
      // enable dropped during POP
      fill(6);
      for (int k = 0; k < 10 && age != 0; k++) tick();
      dut_g.delete();
      for (int k = 0; k < 10 && age != 1; k++) tick();
      chk("reach_pop", 32'(o_fifo_pop != 0), 32'd1);
      i_enable = 1'b0;
      for (int k = 0; k < 12; k++) tick();
      chk("noen_grants", 32'(dut_g.size()), 32'd1);
      chk("noen_busy", 32'(o_busy), 32'd0);
      // asynchronous reset during CAPT
      i_enable = 1'b1;
      fill(6);
      for (int k = 0; k < 20 && age != 2; k++) tick();
      chk("reach_capt", 32'(o_busy && !o_valid && o_fifo_pop == 0), 32'd1);
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs("async");
      tick();
      rst_n = 1'b1;
      dut_g.delete();
      tick();
      chk("post_rst_pop", 32'(o_fifo_pop), 32'd1);
      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            int c;
            c = $urandom_range(0, N - 1);
            if (q[c].size() < 8) q[c].push_back(W'($urandom));
         end
         if ($urandom_range(0, 7) == 0) i_mask = N'($urandom);
         i_enable = ($urandom_range(0, 4) != 0);
         i_ready = $urandom_range(0, 1) == 1;
         tick();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
